// File: rtl/io_scan_pkg.sv
// Shared types and defaults for the io_scan select sequencer.
// The optional abort feature is enabled by defining IO_SCAN_ABORT_EN.
package io_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int          SEL_W_DEF = 10;
    localparam int          SIG_W_DEF = 16;
    localparam logic [15:0] POLY_DEF  = 16'h1021;
    localparam logic [15:0] SEED_DEF  = 16'hFFFF;
    localparam int          KEY_W     = 4;

endpackage

// File: rtl/io_scan_misr.sv
// Serial-input MISR that owns the scan signature register.
// Clears on rst, loads the seed on load, otherwise shifts in din when en is high.
module io_scan_misr
    import io_scan_pkg::*;
#(
    parameter int               SIG_W = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] fb;

    assign fb = sig[SIG_W-1] ? POLY : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ fb ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

endmodule

// File: rtl/io_scan_ctrl.sv
// Select sequencer for the mux/demux I/O path: steps channels, settles, samples, signs.
// Defining IO_SCAN_ABORT_EN adds the abort input and the aborted status output.
module io_scan_ctrl
    import io_scan_pkg::*;
#(
    parameter int               SEL_W    = SEL_W_DEF,
    parameter int               SETTLE   = 2,
    parameter int               SIG_W    = SIG_W_DEF,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(POLY_DEF),
    parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] first_sel,
    input  logic [SEL_W-1:0] last_sel,
    input  logic [KEY_W-1:0] com_key,
    input  logic             sample_in,
    output logic [SEL_W-1:0] mux_sel,
    output logic [SEL_W-1:0] demux_sel,
    output logic [KEY_W-1:0] com_sel,
    output logic             busy,
    output logic             done,
    output logic [SEL_W:0]   ones_cnt,
    output logic [SIG_W-1:0] signature
`ifdef IO_SCAN_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int WAIT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    state_t              state;
    logic [SEL_W-1:0]    sel_reg;
    logic [SEL_W-1:0]    last_lat;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                abort_hit;
    logic                misr_load;
    logic                misr_en;

`ifdef IO_SCAN_ABORT_EN
    assign abort_hit = abort && ((state == WAIT) || (state == SAMPLE));
`else
    assign abort_hit = 1'b0;
`endif

    assign misr_load = (state == IDLE) && start;
    assign misr_en   = (state == SAMPLE) && !abort_hit;

    // The key is folded into mux_sel so the downstream XOR restores sel_reg.
    assign mux_sel   = sel_reg ^ SEL_W'(com_sel);
    assign demux_sel = sel_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_reg  <= '0;
            last_lat <= '0;
            com_sel  <= '0;
            wait_cnt <= '0;
            ones_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef IO_SCAN_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        sel_reg  <= first_sel;
                        last_lat <= last_sel;
                        com_sel  <= com_key;
                        ones_cnt <= '0;
                        wait_cnt <= WAIT_W'(SETTLE);
                        busy     <= 1'b1;
                        state    <= WAIT;
`ifdef IO_SCAN_ABORT_EN
                        aborted  <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (abort_hit) begin
                        state <= DONE;
`ifdef IO_SCAN_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (wait_cnt == WAIT_W'(1)) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (abort_hit) begin
                        state <= DONE;
`ifdef IO_SCAN_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else begin
                        ones_cnt <= ones_cnt + (SEL_W+1)'(sample_in);
                        if (sel_reg == last_lat) begin
                            state <= DONE;
                        end else begin
                            sel_reg  <= sel_reg + 1'b1;
                            wait_cnt <= WAIT_W'(SETTLE);
                            state    <= WAIT;
                        end
                    end
                end
                DONE: begin
                    // busy is held through the done pulse and drops on the following edge.
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    io_scan_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SIG_SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .din  (sample_in),
        .sig  (signature)
    );

endmodule

// File: tb/tb_io_scan_ctrl.sv
// Self-checking bench for io_scan_ctrl against a timing/arithmetic reference model.
// Abort checks are compiled in when IO_SCAN_ABORT_EN is defined.
module tb_io_scan_ctrl;
    import io_scan_pkg::*;

    localparam int          SETTLE = 2;
    localparam int          PER_CH = SETTLE + 1;
    localparam logic [15:0] POLY   = 16'h1021;
    localparam logic [15:0] SEED   = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  first_sel;
    logic [9:0]  last_sel;
    logic [3:0]  com_key;
    logic        sample_in;
    logic [9:0]  mux_sel;
    logic [9:0]  demux_sel;
    logic [3:0]  com_sel;
    logic        busy;
    logic        done;
    logic [10:0] ones_cnt;
    logic [15:0] signature;
`ifdef IO_SCAN_ABORT_EN
    logic        abort;
    logic        aborted;
`endif

    int tests = 0;
    int fails = 0;

    io_scan_ctrl #(.SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_sel (first_sel),
        .last_sel  (last_sel),
        .com_key   (com_key),
        .sample_in (sample_in),
        .mux_sel   (mux_sel),
        .demux_sel (demux_sel),
        .com_sel   (com_sel),
        .busy      (busy),
        .done      (done),
        .ones_cnt  (ones_cnt),
        .signature (signature)
`ifdef IO_SCAN_ABORT_EN
        ,
        .abort     (abort),
        .aborted   (aborted)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic b);
        logic [15:0] shifted;
        shifted = {s[14:0], 1'b0};
        return shifted ^ (s[15] ? POLY : 16'h0000) ^ {15'b0, b};
    endfunction

    // mode: 0 = samples all 0, 1 = samples all 1, 2 = random samples.
    task automatic run_scan(input int f, input int l, input int key, input int mode,
                            input bit poke_start, output logic [15:0] sig_out);
        int          n;
        int          ones;
        int          k;
        logic [15:0] sig;
        logic        b;
        n = ((l - f) & 1023) + 1;
        first_sel = 10'(f);
        last_sel  = 10'(l);
        com_key   = 4'(key);
        start     = 1'b1;
        tick;
        start     = 1'b0;
        first_sel = 10'($urandom);
        last_sel  = 10'($urandom);
        com_key   = 4'($urandom);
        check("start_busy", busy, 1);
        check("start_mux", mux_sel, (f ^ key) & 1023);
        check("start_com", com_sel, key);
        ones = 0;
        sig  = SEED;
        for (int e = 1; e <= n * PER_CH + 1; e++) begin
            if (mode == 2) b = 1'($urandom_range(0, 1));
            else           b = (mode == 1);
            sample_in = b;
            start = (poke_start && e == 2);
            if (e % PER_CH == 0) begin
                k = e / PER_CH;
                check("chan", demux_sel, (f + k - 1) & 1023);
                ones += int'(b);
                sig = misr_ref(sig, b);
            end
            tick;
            check("done", done, (e == n * PER_CH + 1));
        end
        start = 1'b0;
        check("done_busy", busy, 1);
        check("ones", ones_cnt, ones);
        check("sig", signature, sig);
        check("last_sel", demux_sel, l & 1023);
        tick;
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
        check("hold_sig", signature, sig);
        check("hold_com", com_sel, key);
        sig_out = sig;
    endtask

    initial begin
        logic [15:0] s;
        int          f;
        int          span;
        rst       = 1'b1;
        start     = 1'b0;
        first_sel = '0;
        last_sel  = '0;
        com_key   = '0;
        sample_in = 1'b0;
`ifdef IO_SCAN_ABORT_EN
        abort     = 1'b0;
`endif
        tick;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mux", mux_sel, 0);
        check("rst_demux", demux_sel, 0);
        check("rst_com", com_sel, 0);
        check("rst_ones", ones_cnt, 0);
        check("rst_sig", signature, 0);
        rst = 1'b0;
        tick;

        // Basic scan 0..3 with constant 1 samples.
        run_scan(0, 3, 0, 1, 1'b0, s);
        check("basic_sig", s, 16'h0E10);
        check("basic_ones", ones_cnt, 4);

        // Wrap through 1023 -> 0.
        run_scan(1022, 1, 5, 2, 1'b0, s);

        // Key XOR on a single channel.
        run_scan(5, 5, 4'hA, 2, 1'b0, s);
        check("key_mux", mux_sel, 10'h00F);
        check("key_demux", demux_sel, 10'h005);
        check("key_com", com_sel, 4'hA);

        // Start pulse during WAIT is ignored, then single channel with 0 sample.
        run_scan(20, 23, 3, 2, 1'b1, s);
        run_scan(7, 7, 0, 0, 1'b0, s);
        check("single_sig", s, 16'hEFDF);
        check("single_ones", ones_cnt, 0);

        // Reset in the 5th cycle of a scan.
        first_sel = 10'd0;
        last_sel  = 10'd9;
        com_key   = 4'h6;
        start     = 1'b1;
        tick;
        start     = 1'b0;
        sample_in = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_mux", mux_sel, 0);
        check("mrst_ones", ones_cnt, 0);
        check("mrst_sig", signature, 0);
        run_scan(100, 102, 9, 2, 1'b0, s);

        // Full range, all ones: ones_cnt reaches 1024.
        run_scan(300, 299, 1, 1, 1'b0, s);
        check("full_ones", ones_cnt, 1024);

        // Randomized scans, some landing near the wrap point.
        for (int r = 0; r < 8; r++) begin
            f    = (r % 3 == 0) ? int'($urandom_range(1015, 1023)) : int'($urandom_range(0, 1023));
            span = int'($urandom_range(0, 10));
            run_scan(f, (f + span) & 1023, int'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)), s);
        end

`ifdef IO_SCAN_ABORT_EN
        // Abort in the second WAIT of the basic scan.
        first_sel = 10'd0;
        last_sel  = 10'd3;
        com_key   = 4'h0;
        sample_in = 1'b1;
        start     = 1'b1;
        tick;
        start     = 1'b0;
        tick;
        tick;
        tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        check("abort_done", done, 1);
        check("abort_flag", aborted, 1);
        check("abort_ones", ones_cnt, 1);
        check("abort_sig", signature, misr_ref(SEED, 1'b1));
        tick;
        check("abort_idle", busy, 0);
        run_scan(0, 3, 0, 1, 1'b0, s);
        check("abort_clear", aborted, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_scan_ctrl.md
Name: io_scan_ctrl

Overview:
- Upstream select sequencer for the mux_1024x1 → demux_1x1024 I/O path.
- Steps a channel index across a programmed range and drives mux_sel, demux_sel and com_sel.
- Waits a settle interval per channel, samples the observed path bit, and accumulates a ones count and a 16-bit MISR signature.
- Gives the I/O benchmark a self-contained sequential front end with a start/busy/done handshake.

Parameters:
- SEL_W, 10, channel index width; range is 0..2^SEL_W-1.
- SETTLE, 2, wait cycles per channel before sampling; legal range ≥1.
- SIG_W, 16, signature width.
- POLY, 16'h1021, MISR feedback polynomial.
- SIG_SEED, 16'hFFFF, signature value loaded on start.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- first_sel  in  SEL_W  first channel index
- last_sel  in  SEL_W  last channel index
- com_key  in  4  common-select key
- sample_in  in  1  observed path bit for the current channel
- mux_sel  out  SEL_W  sel_reg ^ {zero-extend com_key}, so the downstream effective select equals sel_reg
- demux_sel  out  SEL_W  sel_reg
- com_sel  out  4  latched com_key
- busy  out  1  high from the start edge until DONE exits
- done  out  1  one-cycle pulse
- ones_cnt  out  SEL_W+1  count of samples equal to 1
- signature  out  SIG_W  MISR result

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-scan):
  - state ← IDLE; sel_reg, com_sel, ones_cnt, signature ← 0; busy, done ← 0.
  - Consequently mux_sel = demux_sel = 0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start=1:
  - Latch first_sel, last_sel, com_key.
  - sel_reg ← first_sel; ones_cnt ← 0; signature ← SIG_SEED; wait_cnt ← SETTLE; busy ← 1; go to WAIT.
- WAIT: wait_cnt decrements each cycle; when wait_cnt==1 go to SAMPLE. WAIT therefore occupies exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - ones_cnt += sample_in.
  - signature ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ sample_in.
  - If sel_reg==last_latched, go to DONE.
  - Otherwise sel_reg ← sel_reg+1 modulo 2^SEL_W (1023 wraps to 0), wait_cnt ← SETTLE, go to WAIT.
- DONE (1 cycle): done=1, busy stays 1; next state IDLE with busy ← 0.
- Channel count: N = ((last−first) mod 2^SEL_W) + 1.
  - first==last gives one sample.
  - first>last scans through the wrap point.
  - Full range (last = first−1) gives N=1024; ones_cnt max 1024 fits SEL_W+1 bits.
- Timing: start edge to done-high edge = N·(SETTLE+1)+1 edges.
- start while busy is ignored; inputs first_sel, last_sel and com_key may change freely after the start edge.
- ones_cnt, signature, com_sel and sel_reg hold their final values in IDLE until the next accepted start or reset.

Optional Feature:
- Macro IO_SCAN_ABORT_EN, defined:
  - Adds port abort (in, 1) and status output aborted (out, 1).
  - abort=1 in WAIT or SAMPLE: next state DONE; that SAMPLE's update is suppressed; ones_cnt and signature freeze; aborted ← 1.
  - aborted clears on the next accepted start or on rst.
  - abort in IDLE or DONE has no effect.
- Macro not defined: neither port exists; every scan runs to completion.

Decomposition:
- Package io_scan_pkg:
  - state enum (IDLE, WAIT, SAMPLE, DONE);
  - SEL_W, SIG_W, POLY and SIG_SEED defaults;
  - com_key width constant (4).
- Sub-module io_scan_misr: clk, rst, load (seed), en, din → sig; owns the signature register.

Test Plan:
- Basic scan:
  - Stimulus: first=0, last=3, SETTLE=2, sample_in=1 constant.
  - Required: demux_sel steps 0,1,2,3; done pulses 13 edges after start; ones_cnt=4; signature=16'h0E10.
- Wrap scan:
  - Stimulus: first=1022, last=1.
  - Required: demux_sel sequence 1022,1023,0,1; N=4; single done pulse.
- Key XOR:
  - Stimulus: com_key=4'hA with sel_reg=5.
  - Required: mux_sel=10'h00F, demux_sel=10'h005, com_sel=4'hA.
- Start while busy plus single channel:
  - Stimulus: start pulse during WAIT.
  - Required: ignored. Then first=last=7, sample_in=0: ones_cnt=0, signature=16'hFFFE^16'h1021=16'hEFDF, done 4 edges after start.
- Reset mid-scan:
  - Stimulus: rst=1 in the 5th cycle of a scan.
  - Required: next edge shows busy=0, done=0, mux_sel=0, ones_cnt=0, signature=0; a new start then works normally.
- IO_SCAN_ABORT_EN:
  - Stimulus: abort in the second WAIT of the scan in the basic-scan test.
  - Required: done the next cycle, aborted=1, ones_cnt=1; next start clears aborted.
